// File: rtl/frank_pkg.sv
// Shared definitions for the FRANK6000 program sequencer.
//   ADDR_W_DEF      : default program counter / address width
//   STACK_DEPTH_DEF : default return-stack depth (power of two, >= 2)
//   pc_src_e        : selects where the next program counter value comes from
package frank_pkg;

   localparam int unsigned ADDR_W_DEF      = 8;
   localparam int unsigned STACK_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      PC_INC,
      PC_TARGET,
      PC_POP,
      PC_HOLD
   } pc_src_e;

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO.
//   clk, rst : clock, synchronous active-high reset (clears count only)
//   push     : write data onto the stack (caller guarantees not full)
//   pop      : discard the top entry (caller guarantees not empty)
//   data     : value to push
//   top      : most recently pushed entry (valid when not empty)
//   count    : number of entries held, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// push and pop are never asserted together.
module return_stack
   import frank_pkg::*;
#(
   parameter int unsigned W     = ADDR_W_DEF,
   parameter int unsigned DEPTH = STACK_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               data,
   output logic [W-1:0]               top,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   // The low bits of count address the next free slot; one below it is the
   // top. When full, the low bits wrap to 0 and rd_idx lands on DEPTH-1.
   assign wr_idx = count[IDX_W-1:0];
   assign rd_idx = wr_idx - 1'b1;

   assign top   = mem[rd_idx];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (push) begin
         count <= count + 1'b1;
      end else if (pop) begin
         count <= count - 1'b1;
      end
   end

   // Storage needs no reset: entries are only read below count.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_idx] <= data;
      end
   end

endmodule

// File: rtl/program_counter.sv
// FRANK6000 program counter sequencer.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_en          : advance enable; low holds every register
//   i_jump        : condition-qualified jump taken
//   i_call        : call instruction (acts only with i_jump)
//   i_ret         : return instruction (unconditional)
//   i_target      : jump / call destination
//   o_pc          : registered instruction address
//   o_stack_empty : return stack holds no entries
//   o_stack_full  : return stack holds STACK_DEPTH entries
//   o_err         : sticky stack fault (underflow, overflow, call+ret clash)
module program_counter
   import frank_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_jump,
   input  logic              i_call,
   input  logic              i_ret,
   input  logic [ADDR_W-1:0] i_target,
   output logic [ADDR_W-1:0] o_pc,
   output logic              o_stack_empty,
   output logic              o_stack_full,
   output logic              o_err
);

   pc_src_e                   src;
   logic                      push;
   logic                      pop;
   logic                      err_set;
   logic [ADDR_W-1:0]         pc_inc;
   logic [ADDR_W-1:0]         stk_top;
   logic [$clog2(STACK_DEPTH):0] stk_count;

   assign pc_inc = o_pc + 1'b1;

   return_stack #(
      .W     (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push),
      .pop   (pop),
      .data  (pc_inc),
      .top   (stk_top),
      .count (stk_count),
      .full  (o_stack_full),
      .empty (o_stack_empty)
   );

   // Return outranks everything; a call arriving with it is dropped and
   // flagged. push and pop are therefore mutually exclusive by construction.
   always_comb begin
      src     = PC_HOLD;
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
      if (i_en) begin
         if (i_ret) begin
            if (!o_stack_empty) begin
               src = PC_POP;
               pop = 1'b1;
            end else begin
               src     = PC_INC;
               err_set = 1'b1;
            end
            if (i_jump && i_call) begin
               err_set = 1'b1;
            end
         end else if (i_jump) begin
            src = PC_TARGET;
            if (i_call) begin
               if (!o_stack_full) begin
                  push = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
         end else begin
            src = PC_INC;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_pc  <= '0;
         o_err <= 1'b0;
      end else begin
         o_err <= o_err | err_set;
         case (src)
            PC_INC:    o_pc <= pc_inc;
            PC_TARGET: o_pc <= i_target;
            PC_POP:    o_pc <= stk_top;
            default:   o_pc <= o_pc;
         endcase
      end
   end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: stimulus drives on the falling edge
// and queues the state the reference model predicts after the next rising
// edge; the monitor pops and compares just after every rising edge.
module tb_program_counter;

   localparam int AW    = 8;
   localparam int DEPTH = 4;
   localparam int MASK  = (1 << AW) - 1;

   typedef struct {
      logic [AW-1:0] pc;
      logic          empty;
      logic          full;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          jump = 1'b0;
   logic          call = 1'b0;
   logic          ret = 1'b0;
   logic [AW-1:0] target = '0;
   logic [AW-1:0] pc;
   logic          stack_empty;
   logic          stack_full;
   logic          err;

   int total = 0;
   int bad   = 0;

   exp_t exp_q[$];

   // Reference model state
   int m_pc  = 0;
   int m_stk[$];
   bit m_err = 0;

   program_counter #(
      .ADDR_W      (AW),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_jump        (jump),
      .i_call        (call),
      .i_ret         (ret),
      .i_target      (target),
      .o_pc          (pc),
      .o_stack_empty (stack_empty),
      .o_stack_full  (stack_full),
      .o_err         (err)
   );

   always #5 clk = ~clk;

   task automatic model_step(input bit r, input bit e, input bit j,
                             input bit c, input bit rt, input int t);
      if (r) begin
         m_pc = 0;
         m_stk.delete();
         m_err = 0;
      end else if (e) begin
         if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
               m_err = 1;
               m_pc  = (m_pc + 1) & MASK;
            end
            if (j && c) m_err = 1;
         end else if (j) begin
            if (c) begin
               if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) & MASK);
               else m_err = 1;
            end
            m_pc = t & MASK;
         end else begin
            m_pc = (m_pc + 1) & MASK;
         end
      end
   endtask

   task automatic cyc(input bit r, input bit e, input bit j, input bit c,
                      input bit rt, input int t);
      exp_t x;
      @(negedge clk);
      rst = r; en = e; jump = j; call = c; ret = rt; target = AW'(t);
      model_step(r, e, j, c, rt, t);
      x.pc    = AW'(m_pc);
      x.empty = (m_stk.size() == 0);
      x.full  = (m_stk.size() == DEPTH);
      x.err   = m_err;
      exp_q.push_back(x);
   endtask

   task automatic go_to(input int a);
      cyc(0, 1, 1, 0, 0, a);
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         total++;
         if (pc !== x.pc || stack_empty !== x.empty ||
             stack_full !== x.full || err !== x.err) begin
            bad++;
            $display("FAIL state t=%0t: got pc=%02h empty=%0b full=%0b err=%0b, expected pc=%02h empty=%0b full=%0b err=%0b",
                     $time, pc, stack_empty, stack_full, err,
                     x.pc, x.empty, x.full, x.err);
         end
      end
   end

   initial begin
      // Reset then three plain increments
      cyc(1, 0, 0, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 0, 0, 0);

      // Jump, and the same jump while disabled
      go_to(8'h10);
      cyc(0, 1, 1, 0, 0, 8'h40);
      go_to(8'h10);
      cyc(0, 0, 1, 0, 0, 8'h40);
      cyc(0, 0, 1, 1, 1, 8'h55);

      // Call and return
      go_to(8'h20);
      cyc(0, 1, 1, 1, 0, 8'h80);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1, 0);

      // Not-taken call is a plain increment
      cyc(0, 1, 0, 1, 0, 8'h99);

      // Five nested calls, then four returns
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 0, 8'h10 * (i + 1) + 3);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1, 0);

      // Wrap cases
      cyc(1, 0, 0, 0, 0, 0);
      go_to(8'hFF);
      cyc(0, 1, 0, 0, 0, 0);
      go_to(8'hFF);
      cyc(0, 1, 1, 1, 0, 8'h70);
      cyc(0, 1, 0, 0, 1, 0);
      go_to(8'h05);
      cyc(0, 1, 0, 0, 1, 0);
      repeat (3) cyc(0, 1, 0, 0, 0, 0);

      // Call+ret clash with a non-empty stack
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 0, 8'h60);
      cyc(0, 1, 1, 1, 1, 8'hA0);

      // Reset while a call is presented
      go_to(8'h30);
      cyc(1, 1, 1, 1, 0, 8'h90);
      cyc(0, 1, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 7) != 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 1) == 0),
             ($urandom_range(0, 5) == 0),
             int'($urandom_range(0, MASK)));
      end

      @(negedge clk);
      en = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0; rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
